// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of the single-port main memory.
// One transfer in flight; CPU and DMA/loader share it by round-robin or CPU priority.
module mem_port_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 8,
  parameter int MEM_LAT      = 2,
  parameter int CPU_PRIORITY = 0,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ?
                      $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic          r_owner;
  logic          r_last_owner;
  logic          r_busy;
  logic [SW-1:0] r_starve;

  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic          r_cpu_ack;
  logic          r_dma_ack;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dma_rdata;

  logic          w_any;
  logic          w_grant;
  logic          w_pick_dma;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_wr_done;
  logic          w_cap;
  logic          w_done;

  assign w_any   = cpu_req | dma_req;
  assign w_grant = (r_state == S_IDLE) & w_any;

  // Conflict resolution; a lone requester always wins.
  always_comb begin
    w_pick_dma = 1'b0;
    case ({cpu_req, dma_req})
      2'b11: begin
        if (CPU_PRIORITY == 0)
          w_pick_dma = ~r_last_owner;
        else
          w_pick_dma = (r_starve == STARVE_MAX);
      end
      2'b01:   w_pick_dma = 1'b1;
      default: w_pick_dma = 1'b0;
    endcase
  end

  assign w_we    = w_pick_dma ? dma_we    : cpu_we;
  assign w_addr  = w_pick_dma ? dma_addr  : cpu_addr;
  assign w_wdata = w_pick_dma ? dma_wdata : cpu_wdata;

  assign w_wr_done = (r_state == S_ACCESS) & r_we;
  assign w_cap     = (r_state == S_WAIT) & (r_cnt == '0);
  assign w_done    = w_wr_done | w_cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any)
            r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_we) begin
            r_state <= S_ACK;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0)
            r_state <= S_ACK;
          else
            r_cnt <= r_cnt - CW'(1);
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Grant bookkeeping; last_owner resets to DMA so CPU wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_busy       <= 1'b0;
      r_starve     <= '0;
    end else begin
      if (w_grant) begin
        r_we         <= w_we;
        r_owner      <= w_pick_dma;
        r_last_owner <= w_pick_dma;
        r_busy       <= 1'b1;
        if (w_pick_dma)
          r_starve <= '0;
        else if (dma_req && (r_starve != STARVE_MAX))
          r_starve <= r_starve + SW'(1);
      end else if (r_state == S_ACK) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Memory strobe lives for the single ACCESS cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en    <= w_grant;
      r_mem_we    <= w_grant & w_we;
      r_mem_addr  <= w_grant ? w_addr  : '0;
      r_mem_wdata <= w_grant ? w_wdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_cpu_ack <= w_done & ~r_owner;
      r_dma_ack <= w_done &  r_owner;
      if (w_cap & ~r_owner)
        r_cpu_rdata <= mem_rdata;
      if (w_cap & r_owner)
        r_dma_rdata <= mem_rdata;
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign dma_rdata = r_dma_rdata;
  assign dma_ack   = r_dma_ack;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a round-robin instance with a
// latency-modelled memory, plus a CPU-priority instance for grant order.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  typedef struct {
    int          cyc;
    logic [7:0]  rd;
  } ack_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wd;
    logic        own;
  } en_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;

  logic        cpu_req = 0, cpu_we = 0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        dma_req = 0, dma_we = 0;
  logic [11:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic [7:0]  dma_rdata;
  logic        dma_ack;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy, owner;

  logic        b_cpu_req = 0, b_dma_req = 0;
  logic [7:0]  b_cpu_rdata, b_dma_rdata;
  logic        b_cpu_ack, b_dma_ack;
  logic        b_mem_en, b_mem_we;
  logic [11:0] b_mem_addr;
  logic [7:0]  b_mem_wdata;
  logic        b_busy, b_owner;

  logic [7:0]  mem [4096];
  logic [7:0]  rpipe [LAT];

  ack_t        cpu_q[$];
  ack_t        dma_q[$];
  en_t         en_q[$];
  logic        b_q[$];

  logic [7:0]  last_cpu = '0;
  logic [7:0]  last_dma = '0;

  int          n_tot = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(
    .AW(12), .DW(8), .MEM_LAT(LAT),
    .CPU_PRIORITY(0), .STARVE_LIMIT(3)
  ) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(
    .AW(12), .DW(8), .MEM_LAT(LAT),
    .CPU_PRIORITY(1), .STARVE_LIMIT(3)
  ) u_dut_p (
    .clk(clk), .rst(rst),
    .cpu_req(b_cpu_req), .cpu_we(1'b1),
    .cpu_addr(12'h040), .cpu_wdata(8'h01),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .dma_req(b_dma_req), .dma_we(1'b1),
    .dma_addr(12'h050), .dma_wdata(8'h02),
    .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(8'h00),
    .busy(b_busy), .owner(b_owner)
  );

  // Read data appears exactly LAT cycles after the strobe, 0xEE otherwise.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[12'h005] = 8'h3C;
    mem[12'h001] = 8'h11;
    mem[12'h002] = 8'h22;
  end

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    rpipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 8'hEE;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ack_t a;
    en_t  e;
    #1;
    if (!rst) begin
      if (mem_en) begin
        if (en_q.size() == 0) begin
          chk("mem_en_extra", 1, 0);
        end else begin
          e = en_q.pop_front();
          chk("mem_en_cyc", 32'(cyc), 32'(e.cyc));
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
          chk("owner", 32'(owner), 32'(e.own));
          chk("busy_acc", 32'(busy), 1);
        end
      end else begin
        chk("mem_idle_zero",
            32'({mem_we, mem_addr, mem_wdata}), 0);
      end
      if (cpu_ack) begin
        if (cpu_q.size() == 0) begin
          chk("cpu_ack_extra", 1, 0);
        end else begin
          a = cpu_q.pop_front();
          chk("cpu_ack_cyc", 32'(cyc), 32'(a.cyc));
          chk("cpu_rdata", 32'(cpu_rdata), 32'(a.rd));
        end
      end
      if (dma_ack) begin
        if (dma_q.size() == 0) begin
          chk("dma_ack_extra", 1, 0);
        end else begin
          a = dma_q.pop_front();
          chk("dma_ack_cyc", 32'(cyc), 32'(a.cyc));
          chk("dma_rdata", 32'(dma_rdata), 32'(a.rd));
        end
      end
    end
  end

  task automatic push_en(input int c, input logic we,
                         input logic [11:0] ad,
                         input logic [7:0] wd,
                         input logic own);
    en_t e;
    e.cyc = c; e.we = we; e.addr = ad;
    e.wd = wd; e.own = own;
    en_q.push_back(e);
  endtask

  task automatic push_ack(input logic is_dma, input int c,
                          input logic [7:0] rd);
    ack_t a;
    a.cyc = c; a.rd = rd;
    if (is_dma) dma_q.push_back(a);
    else        cpu_q.push_back(a);
  endtask

  task automatic xfer(input logic is_dma, input logic we,
                      input logic [11:0] ad,
                      input logic [7:0] wd);
    logic done;
    @(negedge clk);
    if (is_dma) begin
      dma_req = 1; dma_we = we; dma_addr = ad; dma_wdata = wd;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = ad; cpu_wdata = wd;
    end
    push_en(cyc + 1, we, ad, wd, is_dma);
    if (!we) begin
      if (is_dma) last_dma = mem[ad];
      else        last_cpu = mem[ad];
    end
    push_ack(is_dma, cyc + (we ? 2 : LAT + 2),
             is_dma ? last_dma : last_cpu);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (is_dma ? dma_ack : cpu_ack) done = 1;
    end
    if (!done) chk("xfer_timeout", 0, 1);
    cpu_req = 0;
    dma_req = 0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    last_cpu = 0;
    last_dma = 0;
  endtask

  initial begin
    int c0;
    int seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_acks", 32'({cpu_ack, dma_ack}), 0);
    chk("rst_rdata", 32'({cpu_rdata, dma_rdata}), 0);
    chk("rst_owner", 32'(owner), 0);
    rst = 0;

    // CPU read, then DMA write
    xfer(0, 0, 12'h005, 8'h00);
    xfer(1, 1, 12'h010, 8'hA5);
    chk("mem_010", 32'(mem[12'h010]), 32'h0A5);

    // back-to-back CPU reads
    xfer(0, 0, 12'h001, 8'h00);
    xfer(0, 0, 12'h002, 8'h00);

    // round-robin with both requesting continuously
    pulse_rst();
    @(negedge clk);
    c0 = cyc;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h020; cpu_wdata = 8'h11;
    dma_req = 1; dma_we = 1; dma_addr = 12'h030; dma_wdata = 8'h22;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_en(c0 + 1 + 3*k, 1, 12'h020, 8'h11, 0);
      else            push_en(c0 + 1 + 3*k, 1, 12'h030, 8'h22, 1);
      push_ack(k % 2 == 1, c0 + 2 + 3*k, 8'h00);
    end
    repeat (11) @(negedge clk);
    cpu_req = 0;
    dma_req = 0;
    repeat (3) @(negedge clk);
    chk("rr_q_empty",
        32'(en_q.size() + cpu_q.size() + dma_q.size()), 0);

    // reset in the middle of a CPU read wait
    xfer(0, 0, 12'h005, 8'h00);
    @(negedge clk);
    push_en(cyc + 1, 0, 12'h005, 8'h00, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005; cpu_wdata = 0;
    repeat (2) @(negedge clk);
    cpu_req = 0;
    chk("t5_busy_pre", 32'(busy), 1);
    rst = 1;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_mem_en", 32'(mem_en), 0);
    chk("t5_cpu_ack", 32'(cpu_ack), 0);
    chk("t5_cpu_rdata", 32'(cpu_rdata), 0);
    chk("t5_owner", 32'(owner), 0);
    repeat (3) @(negedge clk);
    rst = 0;
    last_cpu = 0;
    last_dma = 0;
    xfer(1, 0, 12'h010, 8'h00);
    repeat (4) @(negedge clk);

    // fixed CPU priority with starvation guard
    @(negedge clk);
    for (int k = 0; k < 8; k++) b_q.push_back(k % 4 == 3);
    b_cpu_req = 1;
    b_dma_req = 1;
    seen = 0;
    for (int i = 0; i < 60 && seen < 8; i++) begin
      @(posedge clk);
      #1;
      if (b_mem_en) begin
        chk("prio_owner", 32'(b_owner), 32'(b_q.pop_front()));
        seen++;
      end
    end
    if (seen < 8) chk("prio_timeout", 32'(seen), 8);
    @(negedge clk);
    b_cpu_req = 0;
    b_dma_req = 0;
    repeat (6) @(negedge clk);

    chk("q_left",
        32'(en_q.size() + cpu_q.size() + dma_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
